awb_gain_calc: RTL and testbench

Parametrised auto-white-balance gain calculator: takes per-channel R/G/B means from the statistics stage and produces fixed-point per-channel gains for the gain-apply stage. It supports three target modes: green-reference, external target, and gray-world. All three channel divisions share one sequential restoring divider. Input and output both use valid/ready handshakes, and saturation is flagged per channel.

---
 rtl/awb_pkg.sv | 22 ++
 rtl/seq_divider.sv | 59 +++++
 rtl/awb_gain_calc.sv | 171 +++++++++++++++++
 tb/tb_awb_gain_calc.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/awb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : awb_pkg
// Brief    : Mode encodings and FSM state type for the AWB gain calculator.
// Revision : 1.0
// ============================================================================
package awb_pkg;

  localparam logic [1:0] AWB_GREEN_REF  = 2'd0;
  localparam logic [1:0] AWB_EXT_TARGET = 2'd1;
  localparam logic [1:0] AWB_GRAY_WORLD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DIV   = 3'd2,
    ST_STORE = 3'd3,
    ST_DONE  = 3'd4
  } awb_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Unsigned restoring divider, one quotient bit per cycle.
// Revision : 1.0
// ============================================================================
module seq_divider #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quo
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_den;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_shift;
  logic [W:0]    w_diff;
  logic          w_ge;

  // Dividend bits shift out of the top of r_quo as quotient bits shift in.
  // A zero divisor makes every trial subtraction succeed: quotient all-ones.
  assign w_shift = {r_rem, r_quo[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_den});
  assign w_diff  = w_shift - {1'b0, r_den};

  assign busy = (r_cnt != '0);
  assign done = (r_cnt == CW'(1));
  assign quo  = r_quo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_den <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_quo <= num;
      r_rem <= '0;
      r_den <= den;
      r_cnt <= CW'(W);
    end else if (busy) begin
      r_rem <= w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
      r_quo <= {r_quo[W-2:0], w_ge};
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/awb_gain_calc.sv
`default_nettype none
// ============================================================================
// Module   : awb_gain_calc
// Brief    : Per-channel AWB gain calculator (green-ref / external / gray-world).
// Revision : 1.0
// ============================================================================
module awb_gain_calc
  import awb_pkg::*;
#(
  parameter int MEAN_W = 8,
  parameter int FRAC_W = 8,
  parameter int GAIN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        mode_i,
  input  logic [MEAN_W-1:0] r_mean_i,
  input  logic [MEAN_W-1:0] g_mean_i,
  input  logic [MEAN_W-1:0] b_mean_i,
  input  logic [MEAN_W-1:0] k_mean_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [GAIN_W-1:0] k_r_o,
  output logic [GAIN_W-1:0] k_g_o,
  output logic [GAIN_W-1:0] k_b_o,
  output logic [2:0]        sat_o
);

  localparam int DEN_W = MEAN_W + 2;
  localparam int NUM_W = MEAN_W + 2 + FRAC_W;

  awb_state_e        r_state, w_next;
  logic [1:0]        r_mode;
  logic [MEAN_W-1:0] r_r, r_g, r_b, r_k;
  logic [1:0]        r_ch;
  logic [GAIN_W-1:0] r_stg_r, r_stg_g, r_stg_b;
  logic [2:0]        r_stg_sat;
  logic              r_valid;

  logic [MEAN_W-1:0] w_mean;
  logic [DEN_W-1:0]  w_base, w_den_base;
  logic [NUM_W-1:0]  w_num, w_den, w_quo;
  logic              w_start, w_div_busy, w_div_done;
  logic [GAIN_W-1:0] w_gain, w_clamp;
  logic              w_ovf, w_sat;

  always_comb begin
    w_mean = r_r;
    case (r_ch)
      2'd1:    w_mean = r_g;
      2'd2:    w_mean = r_b;
      default: w_mean = r_r;
    endcase
  end

  // Reserved mode 3 takes the default arm, i.e. green-reference.
  always_comb begin
    w_base     = DEN_W'(r_g);
    w_den_base = DEN_W'(w_mean);
    if (r_mode == AWB_EXT_TARGET) begin
      w_base = DEN_W'(r_k);
    end else if (r_mode == AWB_GRAY_WORLD) begin
      w_base     = DEN_W'(r_r) + DEN_W'(r_g) + DEN_W'(r_b);
      w_den_base = (DEN_W'(w_mean) << 1) + DEN_W'(w_mean);
    end
  end

  assign w_num   = {w_base, {FRAC_W{1'b0}}};
  assign w_den   = NUM_W'(w_den_base);
  assign w_start = (r_state == ST_LOAD);

  seq_divider #(.W(NUM_W)) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .num   (w_num),
    .den   (w_den),
    .busy  (w_div_busy),
    .done  (w_div_done),
    .quo   (w_quo)
  );

  generate
    if (GAIN_W >= NUM_W) begin : g_zext
      assign w_ovf  = 1'b0;
      assign w_gain = GAIN_W'(w_quo);
    end else begin : g_trunc
      assign w_ovf  = |w_quo[NUM_W-1:GAIN_W];
      assign w_gain = w_quo[GAIN_W-1:0];
    end
  endgenerate

  // A zero mean must saturate even when the all-ones quotient fits GAIN_W.
  assign w_sat   = w_ovf | (w_mean == '0);
  assign w_clamp = w_sat ? {GAIN_W{1'b1}} : w_gain;

  assign ready_o = (r_state == ST_IDLE);
  assign valid_o = r_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (valid_i) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_DIV;
      ST_DIV: begin
        if (w_div_done)       w_next = ST_STORE;
        else if (!w_div_busy) w_next = ST_LOAD;
      end
      ST_STORE: w_next = (r_ch == 2'd2) ? ST_DONE : ST_LOAD;
      ST_DONE:  if (r_valid && ready_i) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= '0;
      r_r       <= '0;
      r_g       <= '0;
      r_b       <= '0;
      r_k       <= '0;
      r_ch      <= '0;
      r_stg_r   <= '0;
      r_stg_g   <= '0;
      r_stg_b   <= '0;
      r_stg_sat <= '0;
      r_valid   <= 1'b0;
      k_r_o     <= '0;
      k_g_o     <= '0;
      k_b_o     <= '0;
      sat_o     <= '0;
    end else begin
      if (r_state == ST_IDLE && valid_i) begin
        r_mode <= mode_i;
        r_r    <= r_mean_i;
        r_g    <= g_mean_i;
        r_b    <= b_mean_i;
        r_k    <= k_mean_i;
        r_ch   <= '0;
      end
      if (r_state == ST_STORE) begin
        case (r_ch)
          2'd0:    r_stg_r <= w_clamp;
          2'd1:    r_stg_g <= w_clamp;
          default: r_stg_b <= w_clamp;
        endcase
        r_stg_sat[r_ch] <= w_sat;
        r_ch            <= r_ch + 2'd1;
      end
      // All three gains publish together one cycle into DONE.
      if (r_state == ST_DONE && !r_valid) begin
        r_valid <= 1'b1;
        k_r_o   <= r_stg_r;
        k_g_o   <= r_stg_g;
        k_b_o   <= r_stg_b;
        sat_o   <= r_stg_sat;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_awb_gain_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_awb_gain_calc
// Brief    : Vector-table bench with a result queue for awb_gain_calc.
// Revision : 1.0
// ============================================================================
module tb_awb_gain_calc;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  r, g, b, k;
    logic [15:0] er, eg, eb;
    logic [2:0]  es;
    bit          c12;
    logic [11:0] e12r;
    logic [2:0]  e12s;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [1:0]  mode_i = '0;
  logic [7:0]  r_mean_i = '0, g_mean_i = '0, b_mean_i = '0, k_mean_i = '0;
  logic        ready_o, valid_o, ready12, valid12;
  logic [15:0] k_r_o, k_g_o, k_b_o;
  logic [11:0] k12_r, k12_g, k12_b;
  logic [2:0]  sat_o, sat12;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t sb[$];
  vec_t vecs[7];

  always #5 clk = ~clk;

  awb_gain_calc #(.MEAN_W(8), .FRAC_W(8), .GAIN_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .mode_i(mode_i), .r_mean_i(r_mean_i), .g_mean_i(g_mean_i),
    .b_mean_i(b_mean_i), .k_mean_i(k_mean_i), .valid_o(valid_o),
    .ready_i(ready_i), .k_r_o(k_r_o), .k_g_o(k_g_o), .k_b_o(k_b_o),
    .sat_o(sat_o)
  );

  awb_gain_calc #(.MEAN_W(8), .FRAC_W(8), .GAIN_W(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready12),
    .mode_i(mode_i), .r_mean_i(r_mean_i), .g_mean_i(g_mean_i),
    .b_mean_i(b_mean_i), .k_mean_i(k_mean_i), .valid_o(valid12),
    .ready_i(ready_i), .k_r_o(k12_r), .k_g_o(k12_g), .k_b_o(k12_b),
    .sat_o(sat12)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, input bit chk_lat, input int hold);
    int          n;
    vec_t        e;
    logic [50:0] snap;
    @(negedge clk);
    chk("ready_idle", 64'(ready_o), 64'd1);
    mode_i = v.mode; r_mean_i = v.r; g_mean_i = v.g; b_mean_i = v.b; k_mean_i = v.k;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    sb.push_back(v);
    // Inputs are don't-care after the accepting edge.
    mode_i   = 2'($urandom);
    r_mean_i = 8'($urandom); g_mean_i = 8'($urandom);
    b_mean_i = 8'($urandom); k_mean_i = 8'($urandom);
    n = 0;
    while (!valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!valid_o) chk("valid_timeout", 64'(n), 64'd61);
    if (chk_lat) chk("latency", 64'(n), 64'd61);
    snap = {k_r_o, k_g_o, k_b_o, sat_o};
    for (int i = 0; i < hold; i++) begin
      valid_i = (i == 5);
      @(negedge clk);
      chk("hold_stable", {11'd0, valid_o, ready_o, snap},
          {11'd0, 1'b1, 1'b0, k_r_o, k_g_o, k_b_o, sat_o} & 64'h0 | {11'd0, 2'b10, snap});
    end
    valid_i = 1'b0;
    e = sb.pop_front();
    chk("k_r", 64'(k_r_o), 64'(e.er));
    chk("k_g", 64'(k_g_o), 64'(e.eg));
    chk("k_b", 64'(k_b_o), 64'(e.eb));
    chk("sat", 64'(sat_o), 64'(e.es));
    if (e.c12) begin
      chk("k12_r", 64'(k12_r), 64'(e.e12r));
      chk("sat12", 64'(sat12), 64'(e.e12s));
    end
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    chk("handshake", {62'd0, valid_o, ready_o}, 64'd1);
    chk("kept_after", 64'(k_r_o), 64'(e.er));
    if (hold > 0) chk("queue_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    //          mode  r    g    b    k    er      eg      eb      es    c12  e12r    e12s
    vecs[0] = '{2'd0, 50,  100, 50,  0,   16'd512, 16'd256, 16'd512, 3'b000, 1'b0, 12'd0, 3'b000};
    vecs[1] = '{2'd2, 50,  100, 50,  0,   16'd341, 16'd170, 16'd341, 3'b000, 1'b0, 12'd0, 3'b000};
    vecs[2] = '{2'd1, 64,  128, 255, 128, 16'd512, 16'd256, 16'd128, 3'b000, 1'b0, 12'd0, 3'b000};
    vecs[3] = '{2'd0, 0,   100, 100, 0,   16'hFFFF, 16'd256, 16'd256, 3'b001, 1'b0, 12'd0, 3'b000};
    vecs[4] = '{2'd0, 1,   255, 255, 0,   16'd65280, 16'd256, 16'd256, 3'b000, 1'b1, 12'hFFF, 3'b001};
    vecs[5] = '{2'd3, 50,  100, 25,  7,   16'd512, 16'd256, 16'd1024, 3'b000, 1'b0, 12'd0, 3'b000};
    vecs[6] = '{2'd1, 1,   0,   255, 255, 16'd65280, 16'hFFFF, 16'd256, 3'b010, 1'b0, 12'd0, 3'b000};

    repeat (3) @(negedge clk);
    chk("reset_state", {30'd0, ready_o, valid_o, k_r_o, k_g_o, k_b_o, sat_o} >> 0,
        {30'd0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 3'd0});
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_req(vecs[i], (i == 0), 0);

    // Backpressure with an ignored request pulse, then a normal request.
    do_req(vecs[2], 1'b0, 20);
    do_req(vecs[1], 1'b0, 0);

    // Reset mid-computation.
    @(negedge clk);
    mode_i = vecs[0].mode; r_mean_i = vecs[0].r; g_mean_i = vecs[0].g;
    b_mean_i = vecs[0].b; k_mean_i = vecs[0].k;
    valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    repeat (29) @(negedge clk);
    chk("no_valid_midcalc", 64'(valid_o), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {30'd0, ready_o, valid_o, k_r_o, k_g_o, k_b_o, sat_o},
        {30'd0, 1'b1, 1'b0, 16'd0, 16'd0, 16'd0, 3'd0});
    @(negedge clk);
    rst_n = 1'b1;
    do_req(vecs[5], 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
